// File: rtl/z_core_pkg.sv
// Shared definitions for the z_core memory arbiter: FSM encoding, requester IDs
// and the default timeout.
package z_core_pkg;

    localparam int unsigned ST_IDLE_BIT = 0;
    localparam int unsigned ST_BUSY_BIT = 1;
    localparam int unsigned ST_RESP_BIT = 2;

    typedef enum logic [2:0] {
        StIdle = 3'(1 << ST_IDLE_BIT),
        StBusy = 3'(1 << ST_BUSY_BIT),
        StResp = 3'(1 << ST_RESP_BIT)
    } arb_state_e;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

    // A disabled timeout (0) still needs a one-bit timer to keep widths legal.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/z_core_rr_pick.sv
// Combinational two-way round-robin picker: on a tie the requester that was
// not granted last wins.
module z_core_rr_pick
    import z_core_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       valid_o,
    output logic       winner_o
);

    always_comb begin
        valid_o  = |req_i;
        winner_o = REQ_CORE;
        unique case (req_i)
            2'b01:   winner_o = REQ_CORE;
            2'b10:   winner_o = REQ_DBG;
            2'b11:   winner_o = ~last_grant_i;
            default: winner_o = REQ_CORE;
        endcase
    end

endmodule

// File: rtl/z_core_mem_arbiter.sv
// Two-requester round-robin arbiter in front of the unified memory port, with a
// per-transaction timeout that turns a hung access into an error response.
module z_core_mem_arbiter
    import z_core_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic              clk_i,
    input  logic              reset_ni,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,

    output logic              busy_o,
    output logic              grant_id_o
);

    localparam int unsigned TimerW    = timer_width(TIMEOUT_CYCLES);
    localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [TimerW-1:0] TimerLast =
        TimerW'(TimeoutEn ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_e        state_q;
    logic [TimerW-1:0] timer_q;
    logic              last_grant_q;
    logic              grant_id_q;
    logic              busy_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              m0_ack_q, m1_ack_q;
    logic              m0_err_q, m1_err_q;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

    logic              pick_valid;
    logic              pick_winner;
    logic              timeout_hit;
    logic [DATA_W-1:0] resp_rdata;

    z_core_rr_pick u_pick (
        .req_i        ({m1_req_i, m0_req_i}),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    assign timeout_hit = TimeoutEn && (timer_q == TimerLast);
    assign resp_rdata  = mem_we_q ? '0 : mem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            last_grant_q <= REQ_DBG;
            grant_id_q   <= REQ_CORE;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            // Response outputs are single-cycle pulses unless re-set below.
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;

            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        if (pick_winner == REQ_DBG) begin
                            mem_we_q    <= m1_we_i;
                            mem_addr_q  <= m1_addr_i;
                            mem_wdata_q <= m1_wdata_i;
                        end else begin
                            mem_we_q    <= m0_we_i;
                            mem_addr_q  <= m0_addr_i;
                            mem_wdata_q <= m0_wdata_i;
                        end
                        grant_id_q   <= pick_winner;
                        last_grant_q <= pick_winner;
                        timer_q      <= '0;
                        mem_req_q    <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= StBusy;
                    end
                end

                StBusy: begin
                    // mem_ack takes priority so a late ack on the last cycle succeeds.
                    if (mem_ack_i) begin
                        if (grant_id_q == REQ_DBG) begin
                            m1_ack_q   <= 1'b1;
                            m1_rdata_q <= resp_rdata;
                        end else begin
                            m0_ack_q   <= 1'b1;
                            m0_rdata_q <= resp_rdata;
                        end
                        mem_req_q <= 1'b0;
                        state_q   <= StResp;
                    end else if (timeout_hit) begin
                        if (grant_id_q == REQ_DBG) begin
                            m1_err_q <= 1'b1;
                        end else begin
                            m0_err_q <= 1'b1;
                        end
                        mem_req_q <= 1'b0;
                        state_q   <= StResp;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end

                StResp: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign m0_ack_o    = m0_ack_q;
    assign m1_ack_o    = m1_ack_q;
    assign m0_err_o    = m0_err_q;
    assign m1_err_o    = m1_err_q;
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;
    assign grant_id_o  = grant_id_q;

endmodule

// File: tb/tb_z_core_mem_arbiter.sv
// Directed bench for z_core_mem_arbiter: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_z_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, grant_id;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    z_core_mem_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .m0_req_i    (m0_req),
        .m0_we_i     (m0_we),
        .m0_addr_i   (m0_addr),
        .m0_wdata_i  (m0_wdata),
        .m0_ack_o    (m0_ack),
        .m0_err_o    (m0_err),
        .m0_rdata_o  (m0_rdata),
        .m1_req_i    (m1_req),
        .m1_we_i     (m1_we),
        .m1_addr_i   (m1_addr),
        .m1_wdata_i  (m1_wdata),
        .m1_ack_o    (m1_ack),
        .m1_err_o    (m1_err),
        .m1_rdata_o  (m1_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack),
        .busy_o      (busy),
        .grant_id_o  (grant_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_m0ack"}, {31'd0, m0_ack}, 32'd0);
        check({tag, "_m1ack"}, {31'd0, m1_ack}, 32'd0);
        check({tag, "_m0err"}, {31'd0, m0_err}, 32'd0);
        check({tag, "_m1err"}, {31'd0, m1_err}, 32'd0);
    endtask

    initial begin
        int hi_cnt;
        reset_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        tick();
        tick();
        reset_n = 1'b1;

        // Reset state
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {31'd0, grant_id}, 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check_quiet("rst");

        // Single read from m0, memory acks in the second BUSY cycle
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        tick();
        check("rd_mem_req", {31'd0, mem_req}, 32'd1);
        check("rd_mem_addr", mem_addr, 32'h10);
        check("rd_mem_we", {31'd0, mem_we}, 32'd0);
        check("rd_busy", {31'd0, busy}, 32'd1);
        check("rd_grant", {31'd0, grant_id}, 32'd0);
        tick();
        check("rd_wait_req", {31'd0, mem_req}, 32'd1);
        check_quiet("rd_wait");
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 0; mem_rdata = '0;
        check("rd_m0_ack", {31'd0, m0_ack}, 32'd1);
        check("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check("rd_m1_ack", {31'd0, m1_ack}, 32'd0);
        check("rd_m0_err", {31'd0, m0_err}, 32'd0);
        check("rd_resp_mem_req", {31'd0, mem_req}, 32'd0);
        check("rd_resp_busy", {31'd0, busy}, 32'd1);
        m0_req = 0;
        tick();
        check("rd_idle_ack", {31'd0, m0_ack}, 32'd0);
        check("rd_idle_rdata", m0_rdata, 32'd0);
        check("rd_idle_busy", {31'd0, busy}, 32'd0);

        // Write from m1, held until mem_ack; rdata must come back as 0
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
        tick();
        check("wr_grant", {31'd0, grant_id}, 32'd1);
        tick();
        tick();
        check("wr_mem_req", {31'd0, mem_req}, 32'd1);
        check("wr_mem_we", {31'd0, mem_we}, 32'd1);
        check("wr_mem_addr", mem_addr, 32'h20);
        check("wr_mem_wdata", mem_wdata, 32'h12345678);
        mem_ack = 1; mem_rdata = 32'hAAAA5555;
        tick();
        mem_ack = 0; mem_rdata = '0;
        check("wr_m1_ack", {31'd0, m1_ack}, 32'd1);
        check("wr_m1_rdata", m1_rdata, 32'd0);
        check("wr_m0_ack", {31'd0, m0_ack}, 32'd0);
        m1_req = 0; m1_we = 0;
        tick();

        // Contention from reset: m0, m1, m0 under continuous requests
        reset_n = 0;
        tick();
        reset_n = 1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h100;
        m1_req = 1; m1_we = 0; m1_addr = 32'h200;
        mem_ack = 1; mem_rdata = 32'h11111111;
        tick();
        check("ct1_grant", {31'd0, grant_id}, 32'd0);
        check("ct1_addr", mem_addr, 32'h100);
        tick();
        check("ct1_m0_ack", {31'd0, m0_ack}, 32'd1);
        check("ct1_m1_ack", {31'd0, m1_ack}, 32'd0);
        check("ct1_rdata", m0_rdata, 32'h11111111);
        tick();
        mem_rdata = 32'h22222222;
        tick();
        check("ct2_grant", {31'd0, grant_id}, 32'd1);
        check("ct2_addr", mem_addr, 32'h200);
        tick();
        check("ct2_m1_ack", {31'd0, m1_ack}, 32'd1);
        check("ct2_m0_ack", {31'd0, m0_ack}, 32'd0);
        check("ct2_rdata", m1_rdata, 32'h22222222);
        tick();
        tick();
        check("ct3_grant", {31'd0, grant_id}, 32'd0);
        tick();
        check("ct3_m0_ack", {31'd0, m0_ack}, 32'd1);
        m0_req = 0; m1_req = 0; mem_ack = 0; mem_rdata = '0;
        tick();
        tick();
        check("ct_idle_busy", {31'd0, busy}, 32'd0);

        // Timeout: memory never acks
        m0_req = 1; m0_we = 0; m0_addr = 32'h30;
        hi_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m0_err || m0_ack) break;
            if (mem_req) hi_cnt++;
        end
        check("to_req_cycles", hi_cnt, 32'd16);
        check("to_m0_err", {31'd0, m0_err}, 32'd1);
        check("to_m0_ack", {31'd0, m0_ack}, 32'd0);
        check("to_rdata", m0_rdata, 32'd0);
        check("to_m1_err", {31'd0, m1_err}, 32'd0);
        m0_req = 0;
        tick();
        check("to_idle_busy", {31'd0, busy}, 32'd0);
        check("to_idle_err", {31'd0, m0_err}, 32'd0);

        // mem_ack on the 16th BUSY cycle wins over the timeout
        m0_req = 1; m0_addr = 32'h34;
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("tb_last_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 0; mem_rdata = '0;
        check("tb_m0_ack", {31'd0, m0_ack}, 32'd1);
        check("tb_m0_err", {31'd0, m0_err}, 32'd0);
        check("tb_rdata", m0_rdata, 32'hCAFEF00D);
        m0_req = 0;
        tick();

        // Reset mid-BUSY aborts with no response; m0 wins the first tie afterwards
        m0_req = 1; m0_addr = 32'h40;
        tick();
        check("rb_busy_pre", {31'd0, busy}, 32'd1);
        reset_n = 0;
        tick();
        check("rb_mem_req", {31'd0, mem_req}, 32'd0);
        check("rb_busy", {31'd0, busy}, 32'd0);
        check_quiet("rb");
        m1_req = 1; m1_we = 0; m1_addr = 32'h50;
        reset_n = 1;
        tick();
        check("rb_tie_grant", {31'd0, grant_id}, 32'd0);
        check("rb_tie_addr", mem_addr, 32'h40);
        check_quiet("rb_tie");
        m0_req = 0; m1_req = 0;
        reset_n = 0;
        tick();
        reset_n = 1;
        tick();

        // Stray mem_ack while IDLE
        mem_ack = 1; mem_rdata = 32'h55AA55AA;
        tick();
        tick();
        check("st_mem_req", {31'd0, mem_req}, 32'd0);
        check("st_busy", {31'd0, busy}, 32'd0);
        check("st_m0_rdata", m0_rdata, 32'd0);
        check_quiet("st");
        mem_ack = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
